clk_div_multi: RTL and testbench

Parametrised multi-channel clock divider generating NUM_CH independent divided clocks and matching single-cycle tick strobes from the 100 MHz system clock. Each channel has a runtime-programmable divide ratio, loaded through a shadow register and applied only at that channel's period boundary, so retuning never produces a runt pulse. A global sync request phase-aligns all channels. Feeds camera/VGA/peripheral timing logic in place of per-use fixed dividers.

---
 rtl/clk_div_multi.sv | 97 +++++++++
 tb/tb_clk_div_multi.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent programmable clock dividers with per-channel tick strobes.
// New ratios are shadowed and take effect only at a period boundary or on sync_req.
module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic              clk_100MHz,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [3:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              sync_req,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  logic w_ch_valid;
  assign w_ch_valid = ({1'b0, cfg_ch} < 5'(NUM_CH));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pdiv;
    logic [DIV_W-1:0] r_cnt;
    logic             r_pend;
    logic             r_clk;
    logic             r_tick;
    logic [DIV_W-1:0] w_div_n;
    logic [DIV_W-1:0] w_cnt_n;
    logic [DIV_W-1:0] w_high;
    logic             w_wr;
    logic             w_bound;
    logic             w_restart;
    logic             w_apply;
    logic             w_clk_n;
    logic             w_tick_n;

    assign w_wr = cfg_wr & w_ch_valid & (cfg_ch == 4'(g));

    // Restart the period (applying any pending ratio) at a boundary or sync, otherwise count
    always_comb begin
      w_bound   = (r_div < DIV_W'(2)) || (r_cnt == (r_div - DIV_W'(1)));
      w_restart = w_bound || sync_req;
      w_apply   = w_restart && r_pend;
      w_high    = r_div - (r_div >> 1);
      w_div_n   = r_div;
      w_cnt_n   = DIV_W'(0);
      w_clk_n   = 1'b0;
      w_tick_n  = 1'b0;
      if (w_apply) begin
        w_div_n = r_pdiv;
      end else begin
        w_div_n = r_div;
      end
      if (w_restart) begin
        w_cnt_n  = DIV_W'(0);
        w_clk_n  = (w_div_n != DIV_W'(0));
        w_tick_n = (w_div_n != DIV_W'(0));
      end else begin
        w_cnt_n  = r_cnt + DIV_W'(1);
        w_clk_n  = (w_cnt_n < w_high);
        w_tick_n = 1'b0;
      end
    end

    // Channel state; a write on an apply edge stays pending for the next boundary
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
      if (!rst_n) begin
        r_div  <= DEF_DIV;
        r_pdiv <= DIV_W'(0);
        r_cnt  <= DIV_W'(0);
        r_pend <= 1'b0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        r_div  <= w_div_n;
        r_cnt  <= w_cnt_n;
        r_clk  <= w_clk_n;
        r_tick <= w_tick_n;
        if (w_wr) begin
          r_pdiv <= cfg_div;
          r_pend <= 1'b1;
        end else if (w_apply) begin
          r_pend <= 1'b0;
        end
      end
    end

    assign clk_out[g]     = r_clk;
    assign tick[g]        = r_tick;
    assign cfg_pending[g] = r_pend;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: directed per-edge stimulus with hand-computed
// expected clk_out/tick/cfg_pending, checked by an independent monitor one step after each edge.
module tb_clk_div_multi;

  logic        clk_100MHz;
  logic        rst_n;
  logic        cfg_wr;
  logic [3:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        sync_req;
  logic [3:0]  clk_out;
  logic [3:0]  tick;
  logic [3:0]  cfg_pending;

  typedef struct {
    int       edge_no;
    logic [3:0] exp_clk;
    logic [3:0] exp_tick;
    logic [3:0] exp_pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   edge_cnt;

  clk_div_multi #(
    .NUM_CH(4),
    .DIV_W(16),
    .DEFAULT_DIV(2)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .cfg_wr     (cfg_wr),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .sync_req   (sync_req),
    .clk_out    (clk_out),
    .tick       (tick),
    .cfg_pending(cfg_pending)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  task automatic check4(input string name, input int en, input logic [3:0] act, input logic [3:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s edge=%0d actual=%b required=%b", name, en, act, req);
    end
  endtask

  // Drive one edge's inputs at the falling edge and queue the expected post-edge outputs
  task automatic step(input logic wr, input logic [3:0] ch, input logic [15:0] dv, input logic sy,
                      input logic [3:0] ec, input logic [3:0] et, input logic [3:0] ep);
    exp_t e;
    edge_cnt++;
    cfg_wr   = wr;
    cfg_ch   = ch;
    cfg_div  = dv;
    sync_req = sy;
    e.edge_no  = edge_cnt;
    e.exp_clk  = ec;
    e.exp_tick = et;
    e.exp_pend = ep;
    exp_q.push_back(e);
    @(negedge clk_100MHz);
  endtask

  // Monitor: compare DUT outputs 1 time unit after each rising edge against the queue head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_100MHz);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check4("clk_out", e.edge_no, clk_out, e.exp_clk);
        check4("tick", e.edge_no, tick, e.exp_tick);
        check4("cfg_pending", e.edge_no, cfg_pending, e.exp_pend);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    edge_cnt = 0;
    rst_n    = 1'b0;
    cfg_wr   = 1'b0;
    cfg_ch   = 4'd0;
    cfg_div  = 16'd0;
    sync_req = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    check4("reset_clk_out", 0, clk_out, 4'b0000);
    check4("reset_tick", 0, tick, 4'b0000);
    check4("reset_cfg_pending", 0, cfg_pending, 4'b0000);
    rst_n = 1'b1;

    //    wr    ch     div     sync  clk      tick     pend
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // E1  D=2 first edge cnt=1
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b1111, 4'b1111, 4'b0000); // E2
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // E3
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b1111, 4'b1111, 4'b0000); // E4
    step(1'b1, 4'd1, 16'd5, 1'b0, 4'b0000, 4'b0000, 4'b0010); // E5  ch1<=5 mid-period
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b1111, 4'b1111, 4'b0000); // E6  ch1 applies 5
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b0010, 4'b0000, 4'b0000); // E7
    step(1'b1, 4'd0, 16'd4, 1'b0, 4'b1111, 4'b1101, 4'b0001); // E8  ch0<=4 on its boundary
    step(1'b1, 4'd0, 16'd7, 1'b0, 4'b0000, 4'b0000, 4'b0001); // E9  ch0<=7 overwrites
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b1101, 4'b1101, 4'b0000); // E10 ch0 applies 7
    step(1'b1, 4'd2, 16'd0, 1'b0, 4'b0011, 4'b0010, 4'b0100); // E11 ch2<=0
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b1011, 4'b1000, 4'b0000); // E12 ch2 stopped
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b0011, 4'b0000, 4'b0000); // E13
    step(1'b1, 4'd2, 16'd3, 1'b0, 4'b1000, 4'b1000, 4'b0100); // E14 ch2<=3
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b0100, 4'b0100, 4'b0000); // E15 ch2 applies 3
    step(1'b1, 4'd3, 16'd4, 1'b0, 4'b1110, 4'b1010, 4'b1000); // E16 ch3<=4 on its boundary
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b0011, 4'b0001, 4'b1000); // E17 ch0 wraps after 7
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b1111, 4'b1100, 4'b0000); // E18 ch3 applies 4
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b1101, 4'b0000, 4'b0000); // E19
    step(1'b0, 4'd0, 16'd0, 1'b1, 4'b1111, 4'b1111, 4'b0000); // E20 sync_req
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b1111, 4'b0000, 4'b0000); // E21
    step(1'b1, 4'd4, 16'd9, 1'b0, 4'b0011, 4'b0000, 4'b0000); // E22 cfg_ch=NUM_CH ignored
    step(1'b1, 4'd15, 16'd9, 1'b0, 4'b0101, 4'b0100, 4'b0000); // E23 cfg_ch=15 ignored
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b1100, 4'b1000, 4'b0000); // E24
    step(1'b1, 4'd3, 16'd1, 1'b0, 4'b1010, 4'b0010, 4'b1000); // E25 ch3<=1
    step(1'b0, 4'd0, 16'd0, 1'b1, 4'b1111, 4'b1111, 4'b0000); // E26 sync applies ch3=1
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b1111, 4'b1000, 4'b0000); // E27
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b1011, 4'b1000, 4'b0000); // E28
    step(1'b1, 4'd0, 16'd9, 1'b0, 4'b1101, 4'b1100, 4'b0001); // E29 ch0<=9 pending

    rst_n = 1'b0;
    #1;
    check4("async_rst_clk_out", edge_cnt, clk_out, 4'b0000);
    check4("async_rst_tick", edge_cnt, tick, 4'b0000);
    check4("async_rst_cfg_pending", edge_cnt, cfg_pending, 4'b0000);
    @(negedge clk_100MHz);
    rst_n  = 1'b1;
    cfg_wr = 1'b0;
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // E30 defaults restored, cnt=1
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b1111, 4'b1111, 4'b0000); // E31
    step(1'b0, 4'd0, 16'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000); // E32

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk_100MHz);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
